// File: rtl/risc8_pin_input.sv
// Pad input conditioning for risc8_soc pin_b: per-bit synchroniser, debounce,
// accepted-edge pulses and a sticky, maskable pin-change interrupt flag.
module risc8_pin_input #(
  parameter int                 WIDTH           = 8,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 8,
  parameter logic [WIDTH-1:0]   INIT_VALUE      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] pcmsk,
  input  logic             pcif_clr,
  output logic [WIDTH-1:0] pin_b,
  output logic [WIDTH-1:0] pin_rise,
  output logic [WIDTH-1:0] pin_fall,
  output logic             pcif,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] accept;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VALUE;
    end else begin
      sync_q[0] <= pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // NOTE: default assignment first so no path leaves accept unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync_s[i] != pin_b[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // NOTE: the counter array is ordinary flops, not a RAM, so resetting every
  // entry is intended and required for a clean restart after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      pin_b    <= INIT_VALUE;
      pin_rise <= '0;
      pin_fall <= '0;
      pcif     <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (accept[i]) begin
          pin_b[i] <= sync_s[i];
          cnt_q[i] <= '0;
        end else if (sync_s[i] != pin_b[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end else begin
          cnt_q[i] <= '0;
        end
      end
      pin_rise <= accept & sync_s;
      pin_fall <= accept & ~sync_s;
      // A masked acceptance overrides a coincident clear so no event is lost.
      pcif     <= (|(accept & pcmsk)) | (pcif & ~pcif_clr);
    end
  end

  assign irq = pcif;

endmodule

// File: tb/tb_risc8_pin_input.sv
// Directed scoreboard bench for risc8_pin_input with default parameters:
// expectations are queued per future cycle and compared as the DUT gets there.
module tb_risc8_pin_input;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pad_in;
  logic [7:0] pcmsk;
  logic       pcif_clr;
  logic [7:0] pin_b;
  logic [7:0] pin_rise;
  logic [7:0] pin_fall;
  logic       pcif;
  logic       irq;

  risc8_pin_input dut (
    .clk      (clk),
    .reset    (reset),
    .pad_in   (pad_in),
    .pcmsk    (pcmsk),
    .pcif_clr (pcif_clr),
    .pin_b    (pin_b),
    .pin_rise (pin_rise),
    .pin_fall (pin_fall),
    .pcif     (pcif),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] pin_b;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       pcif;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue an expectation for the state seen ofs edges from now.
  task automatic expect_at(input int ofs, input string tag, input logic [7:0] pb,
                           input logic [7:0] ri, input logic [7:0] fa, input logic pc);
    exp_t e;
    e.cyc   = cyc + ofs;
    e.tag   = tag;
    e.pin_b = pb;
    e.rise  = ri;
    e.fall  = fa;
    e.pcif  = pc;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check({e.tag, ".pin_b"},    32'(pin_b),    32'(e.pin_b));
      check({e.tag, ".pin_rise"}, 32'(pin_rise), 32'(e.rise));
      check({e.tag, ".pin_fall"}, 32'(pin_fall), 32'(e.fall));
      check({e.tag, ".pcif"},     32'(pcif),     32'(e.pcif));
      check({e.tag, ".irq"},      32'(irq),      32'(e.pcif));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    pad_in   = 8'h00;
    pcmsk    = 8'h00;
    pcif_clr = 1'b0;

    // Held in reset.
    expect_at(1, "rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(2, "rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    run(2);

    // Idle after release with pads at the reset value.
    reset = 1'b1;
    for (int k = 1; k <= 50; k++) expect_at(k, "idle", 8'h00, 8'h00, 8'h00, 1'b0);
    run(50);

    // Masked rise on bit 0: accepted at edge 10.
    pcmsk  = 8'h01;
    pad_in = 8'h01;
    expect_at(9,  "rise0_pre",    8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(10, "rise0_acc",    8'h01, 8'h01, 8'h00, 1'b1);
    expect_at(11, "rise0_post",   8'h01, 8'h00, 8'h00, 1'b1);
    expect_at(15, "rise0_sticky", 8'h01, 8'h00, 8'h00, 1'b1);
    run(15);

    // 7-cycle glitch on bit 3 is rejected.
    for (int k = 1; k <= 20; k++) expect_at(k, "glitch3", 8'h01, 8'h00, 8'h00, 1'b1);
    pad_in = 8'h09;
    run(7);
    pad_in = 8'h01;
    run(13);

    // Steady rise on bit 3 (unmasked) lands exactly at edge 10, so the count restarted.
    pad_in = 8'h09;
    expect_at(9,  "rise3_pre",  8'h01, 8'h00, 8'h00, 1'b1);
    expect_at(10, "rise3_acc",  8'h09, 8'h08, 8'h00, 1'b1);
    expect_at(11, "rise3_post", 8'h09, 8'h00, 8'h00, 1'b1);
    run(11);

    // Fall on bit 3.
    pad_in = 8'h01;
    expect_at(9,  "fall3_pre",  8'h09, 8'h00, 8'h00, 1'b1);
    expect_at(10, "fall3_acc",  8'h01, 8'h00, 8'h08, 1'b1);
    expect_at(11, "fall3_post", 8'h01, 8'h00, 8'h00, 1'b1);
    run(11);

    // Write-one-to-clear.
    pcif_clr = 1'b1;
    expect_at(1, "clr",      8'h01, 8'h00, 8'h00, 1'b0);
    expect_at(2, "clr_hold", 8'h01, 8'h00, 8'h00, 1'b0);
    run(1);
    pcif_clr = 1'b0;
    run(1);

    // Unmasked rise on bit 5 pulses but leaves pcif clear.
    pcmsk  = 8'h00;
    pad_in = 8'h21;
    expect_at(9,  "rise5_pre",  8'h01, 8'h00, 8'h00, 1'b0);
    expect_at(10, "rise5_acc",  8'h21, 8'h20, 8'h00, 1'b0);
    expect_at(11, "rise5_post", 8'h21, 8'h00, 8'h00, 1'b0);
    run(11);

    // Clear coincident with a masked acceptance: set wins.
    pcmsk  = 8'h01;
    pad_in = 8'h20;
    expect_at(9,  "setwin_pre",  8'h21, 8'h00, 8'h00, 1'b0);
    expect_at(10, "setwin_acc",  8'h20, 8'h00, 8'h01, 1'b1);
    expect_at(11, "setwin_post", 8'h20, 8'h00, 8'h00, 1'b1);
    run(9);
    pcif_clr = 1'b1;
    run(1);
    pcif_clr = 1'b0;
    run(1);

    // Clear, then widen the mask: past edges must not set pcif.
    pcif_clr = 1'b1;
    expect_at(1, "clr2", 8'h20, 8'h00, 8'h00, 1'b0);
    run(1);
    pcif_clr = 1'b0;
    pcmsk    = 8'hFF;
    for (int k = 1; k <= 5; k++) expect_at(k, "no_retro", 8'h20, 8'h00, 8'h00, 1'b0);
    run(5);

    // Reset with all pads high: immediate reset values, then a normal edge.
    reset  = 1'b0;
    pad_in = 8'hFF;
    expect_at(0, "rst_async", 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    drain();
    expect_at(1, "rst_ff", 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(2, "rst_ff", 8'h00, 8'h00, 8'h00, 1'b0);
    run(2);
    reset = 1'b1;
    expect_at(9,  "init_pre",  8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(10, "init_acc",  8'hFF, 8'hFF, 8'h00, 1'b1);
    expect_at(11, "init_post", 8'hFF, 8'h00, 8'h00, 1'b1);
    run(11);

    // Reset mid-count, then a fresh count from 0 after release.
    pad_in = 8'h00;
    expect_at(5, "midcnt", 8'hFF, 8'h00, 8'h00, 1'b1);
    run(5);
    reset = 1'b0;
    expect_at(0, "rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    drain();
    expect_at(1, "rst_mid_ff", 8'h00, 8'h00, 8'h00, 1'b0);
    run(1);
    pad_in = 8'hFF;
    reset  = 1'b1;
    expect_at(9,  "restart_pre",  8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(10, "restart_acc",  8'hFF, 8'hFF, 8'h00, 1'b1);
    expect_at(11, "restart_post", 8'hFF, 8'h00, 8'h00, 1'b1);
    run(11);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/risc8_pin_input.md
# risc8_pin_input

Input conditioning stage sitting directly upstream of the `risc8_soc` `pin_b` port. It takes raw asynchronous pad levels, synchronises and debounces each bit, and drives the clean `pin_b` value the CPU reads. It also produces per-bit edge pulses and a sticky, maskable pin-change interrupt flag for the SoC interrupt logic.

## Interface

Parameters:
- `WIDTH`, 8, number of pins conditioned.
- `SYNC_STAGES`, 2, synchroniser flops per bit; must be at least 2.
- `DEBOUNCE_CYCLES`, 8, consecutive cycles a new synchronised level must persist before it is accepted; must be at least 1.
- `INIT_VALUE`, 8'h00, reset value of the synchroniser flops and of `pin_b`; width is `WIDTH`.

Ports:
- `clk` input 1: the single clock; all state is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `pad_in` input WIDTH: raw asynchronous pad levels.
- `pcmsk` input WIDTH: pin-change mask; 1 enables that bit to set `pcif`.
- `pcif_clr` input 1: single-cycle clear request for `pcif`, from a CPU write-one-to-clear.
- `pin_b` output WIDTH: debounced, synchronised pin levels to the SoC.
- `pin_rise` output WIDTH: one-cycle pulse per bit on an accepted 0→1.
- `pin_fall` output WIDTH: one-cycle pulse per bit on an accepted 1→0.
- `pcif` output 1: sticky pin-change interrupt flag.
- `irq` output 1: interrupt request to the CPU, equal to `pcif`.

## Operation

- Reset (`reset`=0, asynchronous): synchroniser flops and `pin_b` = `INIT_VALUE`. All debounce counters = 0. `pin_rise`, `pin_fall`, `pcif`, and `irq` = 0.
- Synchroniser: each bit passes through a `SYNC_STAGES`-deep flop chain. `s[i]` is the last stage.
- Debounce, per bit, with two states:
  - MATCH: `s[i]`==`pin_b[i]`, counter held at 0.
  - COUNT: `s[i]`!=`pin_b[i]`. Each cycle in COUNT, the counter increments.
  - Acceptance: at the edge where `s[i]`!=`pin_b[i]` and counter==`DEBOUNCE_CYCLES`-1, `pin_b[i]`<=`s[i]` and the counter resets to 0.
  - Bounce: if `s[i]` returns to `pin_b[i]` before acceptance, the counter clears to 0 and nothing changes.
  - Counter width is clog2(`DEBOUNCE_CYCLES`+1). The counter never wraps.
- Edge pulses: `pin_rise[i]` or `pin_fall[i]` is registered at the acceptance edge. It is high for exactly the first cycle `pin_b[i]` shows the new value, then returns to 0. Multiple bits may pulse in the same cycle.
- `pcif`:
  - Set at any acceptance edge where the changing bit has `pcmsk` set.
  - Cleared when `pcif_clr`=1.
  - If set and clear happen in the same cycle, set wins, so no event is lost.
  - Changing `pcmsk` never sets `pcif` retroactively for past edges.
- `irq` is the `pcif` register itself, with no extra stage.
- Because reset values come from `INIT_VALUE`, a pad held opposite to `INIT_VALUE` at reset release produces a normal accepted edge, including edge pulses and `pcif` if masked.

## Timing

- Pad-to-`pin_b` latency: a pad transition stable from before edge 1 appears on `pin_b` after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults, that is 10 cycles.
- `pin_rise`/`pin_fall`, `pcif`, and `irq` assert on the same edge `pin_b` updates.
- A glitch with synchronised width below `DEBOUNCE_CYCLES` cycles is fully rejected.
- Minimum spacing between accepted edges on one bit is `DEBOUNCE_CYCLES` cycles.
- `pcif_clr` takes effect at the next edge, so `pcif` is 0 the following cycle unless a new set coincides.
- Reset asserted mid-count: all state returns to reset values immediately. Counting restarts from 0 after release.

## Test plan

- Reset release, `pad_in`=8'h00, default params: `pin_b`=0, no pulses, `pcif`=0 for 50 cycles.
- `pcmsk`=8'h01; `pad_in[0]` 0→1 just before edge 1: `pin_b`=8'h01 and `pin_rise`=8'h01 after edge 10. `pin_rise` is 0 after edge 11. `pcif`=`irq`=1 from edge 10 and stays set.
- `pad_in[3]` pulses high for 7 cycles, then low: `pin_b[3]` never changes, no pulses, counter back to 0.
- `pcmsk`=0; `pad_in[5]` 0→1: `pin_b[5]`=1 and `pin_rise[5]` pulses, `pcif` stays 0.
- `pcif`=1, `pcif_clr`=1 for one cycle: `pcif`=0 next cycle. Repeat with `pcif_clr` on the same edge as a masked acceptance: `pcif` stays 1.
- `pad_in`=8'hFF at reset, `INIT_VALUE`=0, `pcmsk`=8'hFF: 10 cycles after release `pin_b`=8'hFF and `pin_rise`=8'hFF for one cycle, `pcif`=1. Assert `reset`=0 at cycle 5 of a new count: everything returns to reset values at once.
